// File: rtl/cla_wide_add_seq.sv
// Wide add/subtract sequencer: one shared 16-bit carry-lookahead adder processes
// a 16*WORDS-bit operation one slice per clock, least-significant slice first.

module cla_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_s,
    output logic        o_cout
);
    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [15:0] w_c;
    logic [3:0]  w_gg;
    logic [3:0]  w_pg;
    logic [3:0]  w_cg;

    // Two-level lookahead: 4-bit groups feed a group-level carry unit.
    always_comb begin
        w_p = i_a ^ i_b;
        w_g = i_a & i_b;
        w_gg = '0;
        w_pg = '0;
        for (int j = 0; j < 4; j++) begin
            w_gg[j] = w_g[4*j+3]
                    | (w_p[4*j+3] & w_g[4*j+2])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
            w_pg[j] = &w_p[4*j +: 4];
        end
    end

    always_comb begin
        w_cg[0] = i_cin;
        w_cg[1] = w_gg[0] | (w_pg[0] & i_cin);
        w_cg[2] = w_gg[1] | (w_pg[1] & w_gg[0]) | (w_pg[1] & w_pg[0] & i_cin);
        w_cg[3] = w_gg[2] | (w_pg[2] & w_gg[1]) | (w_pg[2] & w_pg[1] & w_gg[0])
                | (w_pg[2] & w_pg[1] & w_pg[0] & i_cin);
        o_cout  = w_gg[3] | (w_pg[3] & w_gg[2]) | (w_pg[3] & w_pg[2] & w_gg[1])
                | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0])
                | (w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0] & i_cin);
    end

    always_comb begin
        w_c = '0;
        for (int j = 0; j < 4; j++) begin
            w_c[4*j]   = w_cg[j];
            w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_cg[j]);
            w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                       | (w_p[4*j+1] & w_p[4*j] & w_cg[j]);
            w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                       | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                       | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_cg[j]);
        end
        o_s = w_p ^ w_c;
    end
endmodule

// state | meaning
// IDLE  | ready for a request; result/cout/ovf hold last completed values
// RUN   | one 16-bit slice per clock, carry chained through r_carry
// FIN   | single-cycle done pulse
module cla_wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                start,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] op_a,
    input  logic [16*WORDS-1:0] op_b,
    input  logic                cin,
    input  logic                sub,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] result,
    output logic                cout,
    output logic                ovf
);
    localparam int W  = 16 * WORDS;
    localparam int CW = $clog2(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_result;
    logic          r_cout;
    logic          r_ovf;

    logic [15:0]   w_a_slice;
    logic [15:0]   w_b_slice;
    logic [15:0]   w_sum;
    logic          w_cout;
    logic          w_c15;

    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (r_cnt == k[CW-1:0]) begin
                w_a_slice = r_a[16*k +: 16];
                w_b_slice = r_b[16*k +: 16];
            end
        end
    end

    cla_16bit u_cla (
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cin  (r_carry),
        .o_s    (w_sum),
        .o_cout (w_cout)
    );

    // b is already inverted for subtract, so this is the true carry into the sign bit.
    assign w_c15 = w_a_slice[15] ^ w_b_slice[15] ^ w_sum[15];

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= sub ? ~op_b : op_b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (r_cnt == k[CW-1:0]) begin
                            r_result[16*k +: 16] <= w_sum;
                        end
                    end
                    r_carry <= w_cout;
                    if (r_cnt == LAST) begin
                        r_cout  <= w_cout;
                        r_ovf   <= w_c15 ^ w_cout;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_FIN);
    assign result   = r_result;
    assign cout     = r_cout;
    assign ovf      = r_ovf;
endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Directed and random checks of cla_wide_add_seq (WORDS=4) with a result scoreboard.

module tb_cla_wide_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    logic         CLK = 1'b0;
    logic         reset;
    logic         start;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    cla_wide_add_seq #(.WORDS(WORDS)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .start    (start),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        exp_t         e;
        logic [W:0]   sum;
        logic [W-1:0] bb;
        bb   = s ? ~b : b;
        sum  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : c)};
        e.res = sum[W-1:0];
        e.co  = sum[W];
        e.ov  = (a[W-1] == bb[W-1]) && (e.res[W-1] != a[W-1]);
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic o);
        exp_t e;
        e.res = r;
        e.co  = c;
        e.ov  = o;
        return e;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_timeout", 32'(guard < 50), 1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input exp_t e);
        wait_ready();
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        sb.push_back(e);
        tick();
        start = 1'b0;
    endtask

    // Completion monitor: every done pulse must match the oldest outstanding op.
    always @(posedge CLK) begin
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 128'(done), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 128'(result), 128'(e.res));
                check("cout", 128'(cout), 128'(e.co));
                check("ovf", 128'(ovf), 128'(e.ov));
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        #12;
        check("rst_in_ready", 128'(in_ready), 1);
        check("rst_busy", 128'(busy), 0);
        check("rst_done", 128'(done), 0);
        check("rst_result", 128'(result), 0);
        check("rst_cout", 128'(cout), 0);
        check("rst_ovf", 128'(ovf), 0);
        @(negedge CLK);
        reset = 1'b0;
        tick();

        // Ripple out of the low slice, with cycle-exact timing.
        wait_ready();
        op_a  = 64'h0000_0000_0000_FFFF;
        op_b  = 64'h1;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        sb.push_back(mk(64'h0000_0000_0001_0000, 1'b0, 1'b0));
        tick();
        start = 1'b0;
        for (int c = 0; c <= WORDS + 1; c++) begin
            check($sformatf("t1_busy_c%0d", c), 128'(busy), 128'(c < WORDS));
            check($sformatf("t1_done_c%0d", c), 128'(done), 128'(c == WORDS));
            check($sformatf("t1_ready_c%0d", c), 128'(in_ready), 128'(c == WORDS + 1));
            if (c < WORDS + 1) tick();
        end
        check("t1_hold_result", 128'(result), 128'(64'h0000_0000_0001_0000));

        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, mk(64'h0, 1'b1, 1'b0));
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1));
        do_op(64'h5, 64'h7, 1'b1, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));
        do_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1));

        // Start held high; operand change while busy must not affect the first op.
        wait_ready();
        op_a  = 64'd1;
        op_b  = 64'd2;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        sb.push_back(mk(64'd3, 1'b0, 1'b0));
        tick();
        op_a = 64'd9;
        op_b = 64'd9;
        sb.push_back(mk(64'd18, 1'b0, 1'b0));
        for (int c = 0; c <= WORDS; c++) begin
            check($sformatf("hs_ready_low_c%0d", c), 128'(in_ready), 0);
            tick();
        end
        check("hs_ready_back", 128'(in_ready), 1);
        tick();
        start = 1'b0;
        check("hs_second_busy", 128'(busy), 1);

        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         c;
            logic         s;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = 1'($urandom);
            s = 1'($urandom);
            case ($urandom_range(0, 7))
                0: a = '1;
                1: b = '1;
                2: a = {1'b0, {(W-1){1'b1}}};
                3: b = {1'b1, {(W-1){1'b0}}};
                default: ;
            endcase
            do_op(a, b, c, s, model(a, b, c, s));
        end

        // Abort in the 2nd RUN cycle: outputs clear asynchronously, no done pulse.
        do_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1));
        wait_ready();
        op_a  = 64'hAAAA_BBBB_CCCC_DDDD;
        op_b  = 64'h1111_2222_3333_4444;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_busy_before", 128'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 128'(busy), 0);
        check("abort_done", 128'(done), 0);
        check("abort_result", 128'(result), 0);
        check("abort_cout", 128'(cout), 0);
        check("abort_ovf", 128'(ovf), 0);
        tick();
        tick();
        @(negedge CLK);
        reset = 1'b0;
        for (int c = 0; c < WORDS + 2; c++) begin
            tick();
            check($sformatf("abort_no_done_c%0d", c), 128'(done), 0);
        end
        do_op(64'h1234, 64'h1111, 1'b0, 1'b0, mk(64'h2345, 1'b0, 1'b0));

        for (int g = 0; g < 100 && sb.size() != 0; g++) tick();
        check("scoreboard_drained", 128'(sb.size()), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
